// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, CDB source encodings and entry packing helpers for the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int DEF_ID_WIDTH  = 5;
  localparam int DEF_VAL_WIDTH = 32;
  localparam int DEF_DEPTH     = 4;
  localparam int STAT_W        = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  // Default-width FIFO entry; the top packs {tag, val} in this same order.
  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]  tag;
    logic [DEF_VAL_WIDTH-1:0] val;
  } cdb_entry_t;

  function automatic cdb_src_e otherSrc(input cdb_src_e s);
    return (s == SRC_ALU) ? SRC_LSB : SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO: push/pop/clear with a registered, conservative full flag.
module cdb_src_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              doPush, doPop;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign doPush = push_i && !full_q && !clear_i;
  assign doPop  = pop_i && (count_q != '0) && !clear_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (doPush) tail_d = tail_q + PTR_W'(1);
      if (doPop)  head_d = head_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[tail_q] <= data_i;
  end

  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between the ALU and LSB result FIFOs.
// Optional grant/conflict statistics counters are enabled with CDB_ARB_STATS_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ID_WIDTH  = DEF_ID_WIDTH,
  parameter int VAL_WIDTH = DEF_VAL_WIDTH,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 alu_valid,
  input  logic [ID_WIDTH-1:0]  alu_tag,
  input  logic [VAL_WIDTH-1:0] alu_val,
  output logic                 alu_full,
  input  logic                 lsb_valid,
  input  logic [ID_WIDTH-1:0]  lsb_tag,
  input  logic [VAL_WIDTH-1:0] lsb_val,
  output logic                 lsb_full,
  output logic                 cdb_ready,
  output logic [ID_WIDTH-1:0]  cdb_tag,
  output logic [VAL_WIDTH-1:0] cdb_val,
  output logic                 cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_alu_grants,
  output logic [STAT_W-1:0]    stat_lsb_grants,
  output logic [STAT_W-1:0]    stat_conflicts
`endif
);

  localparam int ENTRY_W = ID_WIDTH + VAL_WIDTH;

  logic               fifoClear;
  logic               aluPush, lsbPush;
  logic               grantAlu, grantLsb;
  logic               aluEmpty, lsbEmpty;
  logic [ENTRY_W-1:0] aluHead, lsbHead;

  cdb_src_e             lastGrant_q, lastGrant_d;
  logic                 cdbReady_q, cdbReady_d;
  logic [ID_WIDTH-1:0]  cdbTag_q, cdbTag_d;
  logic [VAL_WIDTH-1:0] cdbVal_q, cdbVal_d;
  cdb_src_e             cdbSrc_q, cdbSrc_d;

  assign fifoClear = rdy_in && flush_in;
  assign aluPush   = rdy_in && alu_valid;
  assign lsbPush   = rdy_in && lsb_valid;

  cdb_src_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_aluFifo (
    .clk     (clk),
    .rst_in  (rst_in),
    .push_i  (aluPush),
    .pop_i   (grantAlu),
    .clear_i (fifoClear),
    .data_i  ({alu_tag, alu_val}),
    .full_o  (alu_full),
    .empty_o (aluEmpty),
    .head_o  (aluHead)
  );

  cdb_src_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_lsbFifo (
    .clk     (clk),
    .rst_in  (rst_in),
    .push_i  (lsbPush),
    .pop_i   (grantLsb),
    .clear_i (fifoClear),
    .data_i  ({lsb_tag, lsb_val}),
    .full_o  (lsb_full),
    .empty_o (lsbEmpty),
    .head_o  (lsbHead)
  );

  // On a conflict the source that did not win last time takes the bus.
  always_comb begin
    grantAlu    = 1'b0;
    grantLsb    = 1'b0;
    lastGrant_d = lastGrant_q;
    cdbReady_d  = cdbReady_q;
    cdbTag_d    = cdbTag_q;
    cdbVal_d    = cdbVal_q;
    cdbSrc_d    = cdbSrc_q;
    if (rdy_in) begin
      if (flush_in) begin
        cdbReady_d  = 1'b0;
        lastGrant_d = SRC_LSB;
      end else begin
        if (!aluEmpty && (lsbEmpty || otherSrc(lastGrant_q) == SRC_ALU)) begin
          grantAlu = 1'b1;
        end else if (!lsbEmpty) begin
          grantLsb = 1'b1;
        end
        cdbReady_d = grantAlu || grantLsb;
        if (grantAlu) begin
          cdbTag_d    = aluHead[VAL_WIDTH +: ID_WIDTH];
          cdbVal_d    = aluHead[VAL_WIDTH-1:0];
          cdbSrc_d    = SRC_ALU;
          lastGrant_d = SRC_ALU;
        end else if (grantLsb) begin
          cdbTag_d    = lsbHead[VAL_WIDTH +: ID_WIDTH];
          cdbVal_d    = lsbHead[VAL_WIDTH-1:0];
          cdbSrc_d    = SRC_LSB;
          lastGrant_d = SRC_LSB;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      lastGrant_q <= SRC_LSB;
      cdbReady_q  <= 1'b0;
      cdbTag_q    <= '0;
      cdbVal_q    <= '0;
      cdbSrc_q    <= SRC_ALU;
    end else begin
      lastGrant_q <= lastGrant_d;
      cdbReady_q  <= cdbReady_d;
      cdbTag_q    <= cdbTag_d;
      cdbVal_q    <= cdbVal_d;
      cdbSrc_q    <= cdbSrc_d;
    end
  end

  assign cdb_ready = cdbReady_q;
  assign cdb_tag   = cdbTag_q;
  assign cdb_val   = cdbVal_q;
  assign cdb_src   = cdbSrc_q;

`ifdef CDB_ARB_STATS_EN
  logic [STAT_W-1:0] statAluGrants_q, statLsbGrants_q, statConflicts_q;

  // Saturating counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      statAluGrants_q <= '0;
      statLsbGrants_q <= '0;
      statConflicts_q <= '0;
    end else begin
      if (grantAlu && statAluGrants_q != '1) statAluGrants_q <= statAluGrants_q + STAT_W'(1);
      if (grantLsb && statLsbGrants_q != '1) statLsbGrants_q <= statLsbGrants_q + STAT_W'(1);
      if (rdy_in && !aluEmpty && !lsbEmpty && statConflicts_q != '1)
        statConflicts_q <= statConflicts_q + STAT_W'(1);
    end
  end

  assign stat_alu_grants = statAluGrants_q;
  assign stat_lsb_grants = statLsbGrants_q;
  assign stat_conflicts  = statConflicts_q;
`endif

endmodule
